// File: rtl/dec_entry_if.sv
// Operand-entry bus between the board switch/key/display side and dec_entry_reader.
// Signal names follow the board pin names so the block drops straight into the lab top levels.
interface dec_entry_if #(
  parameter int DIGITS = 3,
  parameter int OUT_W  = 10
);
  logic [9:0]          SW;
  logic [3:0]          KEY;
  logic [OUT_W-1:0]    VALUE;
  logic                VALID;
  logic                BUSY;
  logic                ERR;
  logic [4*DIGITS-1:0] DIG_BCD;
  logic [2:0]          COUNT;

  modport master (
    output SW, KEY,
    input  VALUE, VALID, BUSY, ERR, DIG_BCD, COUNT
  );

  modport slave (
    input  SW, KEY,
    output VALUE, VALID, BUSY, ERR, DIG_BCD, COUNT
  );
endinterface

// File: rtl/dec_entry_reader.sv
// Keyed BCD digit entry with decimal-to-binary conversion of the committed digit string.
// Key debouncing is built only when DEC_READER_DEBOUNCE_EN is defined.
module dec_entry_reader #(
  parameter int DIGITS          = 3,
  parameter int OUT_W           = 10,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic        CLOCK_50,
  input logic        RESET,
  dec_entry_if.slave bus
);

  localparam int DW = 4 * DIGITS;
  localparam int AW = OUT_W + 4;
  localparam logic [1:0] LAST_STEP = 2'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  // Key synchronizer: buttons idle high, so reset to 1 avoids a spurious press.
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] r_deb_prev;
  logic [3:0] w_deb;
  logic [3:0] w_press;

  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (RESET) begin
      r_sync1    <= '1;
      r_sync2    <= '1;
      r_deb_prev <= '1;
    end else begin
      r_sync1    <= bus.KEY;
      r_sync2    <= r_sync1;
      r_deb_prev <= w_deb;
    end
  end

`ifdef DEC_READER_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [3:0]    r_deb;
  logic [CW-1:0] r_db_cnt [4];

  // A key level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_deb <= '1;
      for (int k = 0; k < 4; k++) r_db_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (r_sync2[k] == r_deb[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_deb[k]    <= r_sync2[k];
          r_db_cnt[k] <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + CW'(1);
        end
      end
    end
  end

  assign w_deb = r_deb;
`else
  logic w_unused_db;
  assign w_unused_db = (DEBOUNCE_CYCLES > 0);
  assign w_deb       = r_sync2;
`endif

  assign w_press = r_deb_prev & ~w_deb;

  logic w_unused_sw;
  assign w_unused_sw = |bus.SW[9:4];

  state_t            r_state, w_state_next;
  logic [DW-1:0]     r_dig, w_dig_next;
  logic [2:0]        r_cnt, w_cnt_next;
  logic              r_err, w_err_next;
  logic [AW-1:0]     r_acc, w_acc_next;
  logic [1:0]        r_step, w_step_next;
  logic [OUT_W-1:0]  r_value, w_value_next;

  logic [3:0]    w_sw_digit;
  logic [DW-1:0] w_dig_shift;
  logic [3:0]    w_cur_digit;
  logic [AW-1:0] w_acc_step;

  assign w_sw_digit  = bus.SW[3:0];
  // Most significant held digit first; unentered high digits read as zero.
  assign w_dig_shift = r_dig >> {r_step, 2'b00};
  assign w_cur_digit = w_dig_shift[3:0];
  assign w_acc_step  = (r_acc << 3) + (r_acc << 1) + AW'(w_cur_digit);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_next = r_state;
    w_dig_next   = r_dig;
    w_cnt_next   = r_cnt;
    w_err_next   = r_err;
    w_acc_next   = r_acc;
    w_step_next  = r_step;
    w_value_next = r_value;

    if (w_press[3]) begin
      w_state_next = S_IDLE;
      w_dig_next   = '0;
      w_cnt_next   = '0;
      w_err_next   = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_press[2]) begin
            w_state_next = S_CONV;
            w_acc_next   = '0;
            w_step_next  = LAST_STEP;
          end else if (w_press[1]) begin
            if (r_cnt != 3'd0) begin
              w_dig_next = r_dig >> 4;
              w_cnt_next = r_cnt - 3'd1;
            end
          end else if (w_press[0]) begin
            if (w_sw_digit > 4'd9 || r_cnt == 3'(DIGITS)) begin
              w_err_next = 1'b1;
            end else begin
              w_dig_next = (r_dig << 4) | DW'(w_sw_digit);
              w_cnt_next = r_cnt + 3'd1;
            end
          end
        end
        S_CONV: begin
          w_acc_next  = w_acc_step;
          w_step_next = r_step - 2'd1;
          // The result is loaded on the final step so VALUE is new in the same cycle VALID rises.
          if (r_step == 2'd0) begin
            w_state_next = S_DONE;
            if (|w_acc_step[AW-1:OUT_W]) begin
              w_value_next = '1;
              w_err_next   = 1'b1;
            end else begin
              w_value_next = w_acc_step[OUT_W-1:0];
            end
          end
        end
        S_DONE: begin
          w_state_next = S_IDLE;
          w_dig_next   = '0;
          w_cnt_next   = '0;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_dig   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_acc   <= '0;
      r_step  <= '0;
      r_value <= '0;
    end else begin
      r_state <= w_state_next;
      r_dig   <= w_dig_next;
      r_cnt   <= w_cnt_next;
      r_err   <= w_err_next;
      r_acc   <= w_acc_next;
      r_step  <= w_step_next;
      r_value <= w_value_next;
    end
  end

  assign bus.VALUE   = r_value;
  assign bus.VALID   = (r_state == S_DONE);
  assign bus.BUSY    = (r_state != S_IDLE);
  assign bus.ERR     = r_err;
  assign bus.DIG_BCD = r_dig;
  assign bus.COUNT   = r_cnt;

endmodule

// File: tb/tb_dec_entry_reader.sv
// Directed bench for dec_entry_reader: a vector table of single key presses plus
// hand-written sequences for abort, dropped keys, priority, debounce and reset.
module tb_dec_entry_reader;

  localparam int NCYC = 40;
`ifdef DEC_READER_DEBOUNCE_EN
  localparam int LAT       = 6;
  localparam int SHORT_CNT = 0;
  localparam int RST_HOLD  = 6;
`else
  localparam int LAT       = 2;
  localparam int SHORT_CNT = 1;
  localparam int RST_HOLD  = 2;
`endif

  logic clk;
  logic RESET;

  dec_entry_if #(.DIGITS(3), .OUT_W(10)) bus ();

  dec_entry_reader #(
    .DIGITS(3),
    .OUT_W(10),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLOCK_50(clk),
    .RESET   (RESET),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic valid_log [NCYC];
  logic busy_log  [NCYC];

  typedef struct {
    int          key;
    logic [3:0]  sw;
    logic [11:0] dig;
    logic [2:0]  cnt;
    logic        err;
    logic [9:0]  val;
    int          vcnt;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Keys are lowered at the negedge of cycle t[j] (negative = untouched) and released hold
  // cycles later; RESET pulses for one cycle at t_rst. Outputs are logged at each negedge.
  task automatic run_seq(input int t0, input int t1, input int t2, input int t3,
                         input int hold, input int t_rst, input logic [3:0] sw);
    int t [4];
    t = '{t0, t1, t2, t3};
    bus.SW = {6'b0, sw};
    for (int k = 0; k < NCYC; k++) begin
      @(negedge clk);
      valid_log[k] = bus.VALID;
      busy_log[k]  = bus.BUSY;
      for (int j = 0; j < 4; j++) begin
        if (t[j] >= 0 && k == t[j])        bus.KEY[j] = 1'b0;
        if (t[j] >= 0 && k == t[j] + hold) bus.KEY[j] = 1'b1;
      end
      RESET = (k == t_rst);
    end
  endtask

  function automatic int valid_count();
    int n = 0;
    for (int k = 0; k < NCYC; k++) if (valid_log[k]) n++;
    return n;
  endfunction

  function automatic int valid_first();
    for (int k = 0; k < NCYC; k++) if (valid_log[k]) return k;
    return -1;
  endfunction

  function automatic int busy_count();
    int n = 0;
    for (int k = 0; k < NCYC; k++) if (busy_log[k]) n++;
    return n;
  endfunction

  task automatic press(input int key, input logic [3:0] sw, input int hold);
    case (key)
      0:       run_seq(0, -1, -1, -1, hold, -1, sw);
      1:       run_seq(-1, 0, -1, -1, hold, -1, sw);
      2:       run_seq(-1, -1, 0, -1, hold, -1, sw);
      default: run_seq(-1, -1, -1, 0, hold, -1, sw);
    endcase
  endtask

  initial begin
    // key: 0 enter, 1 delete, 2 commit, 3 clear
    vecs[0]  = '{0, 4'h1, 12'h001, 3'd1, 1'b0, 10'd0,   0};
    vecs[1]  = '{0, 4'h2, 12'h012, 3'd2, 1'b0, 10'd0,   0};
    vecs[2]  = '{0, 4'h3, 12'h123, 3'd3, 1'b0, 10'd0,   0};
    vecs[3]  = '{0, 4'h7, 12'h123, 3'd3, 1'b1, 10'd0,   0};
    vecs[4]  = '{2, 4'h0, 12'h000, 3'd0, 1'b1, 10'd123, 1};
    vecs[5]  = '{3, 4'h0, 12'h000, 3'd0, 1'b0, 10'd123, 0};
    vecs[6]  = '{0, 4'hB, 12'h000, 3'd0, 1'b1, 10'd123, 0};
    vecs[7]  = '{3, 4'h0, 12'h000, 3'd0, 1'b0, 10'd123, 0};
    vecs[8]  = '{2, 4'h0, 12'h000, 3'd0, 1'b0, 10'd0,   1};
    vecs[9]  = '{0, 4'h9, 12'h009, 3'd1, 1'b0, 10'd0,   0};
    vecs[10] = '{0, 4'h8, 12'h098, 3'd2, 1'b0, 10'd0,   0};
    vecs[11] = '{1, 4'h0, 12'h009, 3'd1, 1'b0, 10'd0,   0};
    vecs[12] = '{1, 4'h0, 12'h000, 3'd0, 1'b0, 10'd0,   0};
    vecs[13] = '{1, 4'h0, 12'h000, 3'd0, 1'b0, 10'd0,   0};
    vecs[14] = '{0, 4'h4, 12'h004, 3'd1, 1'b0, 10'd0,   0};
    vecs[15] = '{0, 4'h5, 12'h045, 3'd2, 1'b0, 10'd0,   0};
    vecs[16] = '{2, 4'h0, 12'h000, 3'd0, 1'b0, 10'd45,  1};
    vecs[17] = '{0, 4'h6, 12'h006, 3'd1, 1'b0, 10'd45,  0};

    RESET   = 1'b1;
    bus.KEY = 4'hF;
    bus.SW  = '0;
    repeat (3) @(negedge clk);
    check("reset VALUE",   32'(bus.VALUE),   0);
    check("reset VALID",   32'(bus.VALID),   0);
    check("reset BUSY",    32'(bus.BUSY),    0);
    check("reset ERR",     32'(bus.ERR),     0);
    check("reset DIG_BCD", 32'(bus.DIG_BCD), 0);
    check("reset COUNT",   32'(bus.COUNT),   0);
    RESET = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      press(vecs[i].key, vecs[i].sw, 6);
      check($sformatf("v%0d DIG_BCD", i), 32'(bus.DIG_BCD), 32'(vecs[i].dig));
      check($sformatf("v%0d COUNT", i),   32'(bus.COUNT),   32'(vecs[i].cnt));
      check($sformatf("v%0d ERR", i),     32'(bus.ERR),     32'(vecs[i].err));
      check($sformatf("v%0d VALUE", i),   32'(bus.VALUE),   32'(vecs[i].val));
      check($sformatf("v%0d VALID pulses", i), 32'(valid_count()), 32'(vecs[i].vcnt));
      if (vecs[i].vcnt == 1) begin
        check($sformatf("v%0d VALID cycle", i), 32'(valid_first()), 32'(LAT + 4));
        check($sformatf("v%0d BUSY cycles", i), 32'(busy_count()),  4);
        check($sformatf("v%0d BUSY start", i),  32'(busy_log[LAT + 1]), 1);
      end
    end

    // Abort: clear lands in the second conversion cycle.
    run_seq(-1, -1, 0, 2, 6, -1, 4'h0);
    check("abort VALID pulses", 32'(valid_count()), 0);
    check("abort VALUE kept",   32'(bus.VALUE), 45);
    check("abort BUSY conv2",   32'(busy_log[LAT + 2]), 1);
    check("abort BUSY after",   32'(busy_log[LAT + 3]), 0);
    check("abort COUNT",        32'(bus.COUNT), 0);
    check("abort DIG_BCD",      32'(bus.DIG_BCD), 0);

    // Priority: commit beats enter; delete beats enter.
    run_seq(0, -1, 0, -1, 6, -1, 4'h3);
    check("prio commit VALID",  32'(valid_count()), 1);
    check("prio commit VALUE",  32'(bus.VALUE), 0);
    check("prio commit COUNT",  32'(bus.COUNT), 0);
    press(0, 4'h5, 6);
    run_seq(0, 0, -1, -1, 6, -1, 4'h6);
    check("prio delete COUNT",   32'(bus.COUNT), 0);
    check("prio delete DIG_BCD", 32'(bus.DIG_BCD), 0);

    // Enter during conversion is dropped.
    press(0, 4'h7, 6);
    run_seq(1, -1, 0, -1, 6, -1, 4'h5);
    check("drop VALID pulses", 32'(valid_count()), 1);
    check("drop VALUE",        32'(bus.VALUE), 7);
    check("drop COUNT",        32'(bus.COUNT), 0);
    check("drop DIG_BCD",      32'(bus.DIG_BCD), 0);

    // Debounce: a 3-cycle press versus a 6-cycle press.
    press(0, 4'h4, 3);
    check("short press COUNT", 32'(bus.COUNT), 32'(SHORT_CNT));
    press(3, 4'h0, 6);
    press(0, 4'h4, 6);
    check("long press COUNT",   32'(bus.COUNT), 1);
    check("long press DIG_BCD", 32'(bus.DIG_BCD), 12'h004);

    // Reset in the middle of a conversion.
    run_seq(-1, -1, 0, -1, RST_HOLD, LAT + 2, 4'h0);
    check("rst conv VALID pulses", 32'(valid_count()), 0);
    check("rst conv VALUE",        32'(bus.VALUE), 0);
    check("rst conv BUSY after",   32'(busy_log[LAT + 3]), 0);
    check("rst conv COUNT",        32'(bus.COUNT), 0);
    check("rst conv ERR",          32'(bus.ERR), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dec_entry_reader.md
# dec_entry_reader

Decimal operand entry block for the switch/key/seven-segment lab designs. The user keys a multi-digit decimal number one BCD digit at a time (digit on SW[3:0], strobe on a KEY button). The block then converts the digit string into a binary operand for the arithmetic datapath, performing the reverse of the binary-to-decimal display path. The live digit register is also exported, so the existing digit-to-segment decoders can echo the entry on HEX0..HEX3.

## Interface
- DIGITS, 3: maximum number of decimal digits held (1..4).
- OUT_W, 10: width of the binary result VALUE.
- DEBOUNCE_CYCLES, 500000: stable-level cycles required to accept a key change. Used only when the debounce feature is compiled in.

Ports:
- CLOCK_50  in  1: the single clock. All logic is on its rising edge.
- RESET  in  1: synchronous, active-high reset.
- SW  in  10: SW[3:0] is the digit value. SW[9:4] is unused.
- KEY  in  4: active-low buttons.
  - KEY[0] enters a digit.
  - KEY[1] deletes the last digit.
  - KEY[2] commits the entry.
  - KEY[3] clears.
- VALUE  out  OUT_W: last committed binary value.
- VALID  out  1: one-cycle pulse when VALUE is updated.
- BUSY  out  1: high in the CONV and DONE states.
- ERR  out  1: sticky error flag.
- DIG_BCD  out  4*DIGITS: entered digits. The least significant digit (most recently entered) is in [3:0].
- COUNT  out  3: number of digits currently held.

## Operation
- KEY passes through a 2-flop synchronizer (reset value 1), then the debouncer.
- A press event is a debounced 1->0 transition. An event lasts exactly one cycle.
- If several press events occur in the same cycle, only the highest-priority one acts: CLEAR > COMMIT > DELETE > ENTER.
- State machine states: IDLE, CONV, DONE.
- **IDLE / ENTER:**
  - SW[3:0] > 9: set ERR; digits unchanged.
  - COUNT == DIGITS: set ERR; digits unchanged.
  - Otherwise: DIG_BCD <= {DIG_BCD shifted left 4, SW[3:0]}; COUNT++.
- **IDLE / DELETE:**
  - COUNT == 0: no effect and no error.
  - Otherwise: DIG_BCD shifts right 4 with zero fill; COUNT--.
- **IDLE / COMMIT:** go to CONV; the accumulator is cleared.
- **CONV:** runs exactly DIGITS cycles, processing digits most significant first.
  - Each cycle: acc <= acc*10 + digit.
  - Unentered high digits are 0, so leading zeros are harmless.
  - acc has width OUT_W+4.
  - After the last step, go to DONE.
- **DONE (one cycle):**
  - If acc > 2^OUT_W-1: VALUE <= all ones and ERR is set (saturate).
  - Otherwise VALUE <= acc[OUT_W-1:0].
  - VALID = 1; DIG_BCD <= 0; COUNT <= 0; return to IDLE.
- A commit with COUNT == 0 yields VALUE = 0 with VALID.
- ENTER, DELETE and COMMIT events that occur in CONV or DONE are dropped. They are not queued.
- **CLEAR (any state):**
  - Clears DIG_BCD, COUNT and ERR, and forces IDLE.
  - In CONV it aborts: no VALID is issued and VALUE keeps its previous value.
  - VALUE itself is never cleared by CLEAR.
- ERR clears only on CLEAR or RESET.

## Timing
- Reset values:
  - VALUE 0, VALID 0, BUSY 0, ERR 0, DIG_BCD 0, COUNT 0.
  - State IDLE; synchronizer and debounced levels 1.
- Reset mid-conversion behaves identically to reset from idle. No VALID is issued.
- Input latency: a KEY edge reaches the press event after 2 synchronizer cycles plus the debounce interval.
- Digit timing: with the press event in cycle E, DIG_BCD and COUNT change at the clock edge ending cycle E and are visible in cycle E+1.
- Commit timing, with the event in cycle E:
  - CONV occupies cycles E+1..E+DIGITS.
  - DONE, VALID and the new VALUE appear in cycle E+DIGITS+1.
  - BUSY is high for cycles E+1..E+DIGITS+1.
- VALUE holds until the next successful DONE.
- Debounce: the debounced level follows the synchronized level after DEBOUNCE_CYCLES consecutive equal samples. Any change of the synchronized level restarts the per-key counter.

## Configuration
- DEC_READER_DEBOUNCE_EN defined:
  - Per-key counters are implemented as described in Timing.
- DEC_READER_DEBOUNCE_EN not defined:
  - The debounced level equals the synchronized level, so an event occurs 2 cycles after the KEY edge.
  - No counters are built and DEBOUNCE_CYCLES is ignored.
  - This build is for simulation and for boards with hardware-debounced keys.

## Test plan
Bench uses DIGITS=3, OUT_W=10, DEBOUNCE_CYCLES=4, with the macro defined.
- **Enter and commit:** RESET; enter 1, 2, 3; commit with the event in cycle E.
  - DIG_BCD is 12'h123 before the commit.
  - VALID is high only in cycle E+4, with VALUE=123.
  - After the commit, COUNT=0 and DIG_BCD=0.
- **Overflow digit:** with 3 digits held (12'h123), enter 7.
  - ERR=1; DIG_BCD stays 12'h123.
  - A commit still gives VALUE=123 with ERR still 1.
- **Invalid digit:** SW[3:0]=4'hB with ENTER.
  - ERR=1; COUNT unchanged.
  - CLEAR then gives ERR=0.
- **Delete:** enter 9, 8, then delete.
  - DIG_BCD=12'h009, COUNT=1.
  - Two more deletes give COUNT=0 with ERR=0.
- **Debounce:** KEY[0] held low for 3 cycles then released gives no digit. Held low for 6 cycles gives exactly one digit.
- **Abort and drop:** commit 45 (VALUE=45); enter 6; commit; assert CLEAR in the second CONV cycle.
  - No VALID; VALUE stays 45; BUSY is low the next cycle.
  - A KEY[0] press during CONV is dropped.
